// File: rtl/timer_unit_pkg.sv
// -----------------------------------------------------------------------------
// timer_unit_pkg
//   Shared constants for the memory-mapped countdown timers:
//     - bus windows of TIMER0 / TIMER1
//     - word offsets of the CTRL / PRESET / COUNT registers
//     - CTRL bit positions
//     - FSM state encodings
//     - MODE field encodings
//   Optional feature macro consumed by timer_unit: TIMER_AUTORELOAD_EN.
// -----------------------------------------------------------------------------
package timer_unit_pkg;

   // Byte-address windows of the two timer instances.
   localparam logic [31:0] TIMER0_LSA = 32'h0000_7F00;
   localparam logic [31:0] TIMER0_MSA = 32'h0000_7F0B;
   localparam logic [31:0] TIMER1_LSA = 32'h0000_7F10;
   localparam logic [31:0] TIMER1_MSA = 32'h0000_7F1B;

   // Word offsets, i.e. ADDR[3:2].
   localparam logic [1:0] CTRL_OFS   = 2'd0;
   localparam logic [1:0] PRESET_OFS = 2'd1;
   localparam logic [1:0] COUNT_OFS  = 2'd2;
   localparam logic [1:0] RSVD_OFS   = 2'd3;

   // CTRL bit positions.
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;

   // FSM state encodings.
   localparam logic [1:0] TIMER_IDLE = 2'd0;
   localparam logic [1:0] TIMER_LOAD = 2'd1;
   localparam logic [1:0] TIMER_CNT  = 2'd2;
   localparam logic [1:0] TIMER_INT  = 2'd3;

   // MODE encodings; 2'b1x behaves as one-shot.
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // True only for the exact auto-reload encoding.
   function automatic logic is_reload_mode(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage

// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
//   Memory-mapped countdown timer on the data-memory bus. Software programs
//   PRESET and CTRL, the FSM loads COUNT from PRESET and decrements it to 0,
//   then raises irq_flag. irq = irq_flag & CTRL.IM.
//
//   Configuration macro: TIMER_AUTORELOAD_EN
//     defined   : MODE=01 reloads COUNT and pulses irq for one cycle.
//     undefined : MODE=01 behaves as one-shot (MODE still reads back).
//
//   Ports
//     clk      in   1      rising-edge clock
//     reset_n  in   1      asynchronous active-low reset
//     sel      in   1      address falls inside this timer's window
//     addr     in   2      word offset: 0=CTRL 1=PRESET 2=COUNT 3=reserved
//     wr_en    in   4      byte enables; only a full-word write commits
//     wdata    in   32     write data
//     rdata    out  32     combinational read of the addressed register
//     irq      out  1      level interrupt request
// -----------------------------------------------------------------------------
module timer_unit
   import timer_unit_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int CTRL_W = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [3:0]  wr_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]        state_q,    state_d;
   logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
   logic [CNT_W-1:0]  preset_q,   preset_d;
   logic [CNT_W-1:0]  count_q,    count_d;
   logic              irq_flag_q, irq_flag_d;

   logic wr_commit;
   logic auto_reload;

   // Byte or half-word stores into the timer are ignored completely.
   assign wr_commit = sel && (wr_en == 4'b1111);

`ifdef TIMER_AUTORELOAD_EN
   assign auto_reload = is_reload_mode(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);
`else
   assign auto_reload = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Next-state logic. The FSM always acts on the registered CTRL value, so a
   // freshly written EN is only seen on the following edge. The software write
   // is applied last so it overrides any hardware update of CTRL / irq_flag
   // made on the same edge.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      case (state_q)
         TIMER_IDLE: begin
            if (ctrl_q[CTRL_EN_BIT]) begin
               state_d = TIMER_LOAD;
            end
         end
         TIMER_LOAD: begin
            count_d = preset_q;
            state_d = TIMER_CNT;
         end
         TIMER_CNT: begin
            if (!ctrl_q[CTRL_EN_BIT]) begin
               // Disabled mid-count: COUNT freezes at its current value.
               state_d = TIMER_IDLE;
            end else if (count_q > CNT_ONE) begin
               count_d = count_q - CNT_ONE;
            end else begin
               // Covers PRESET=0 as well, so COUNT never underflows.
               count_d    = '0;
               irq_flag_d = 1'b1;
               state_d    = TIMER_INT;
            end
         end
         TIMER_INT: begin
            if (auto_reload) begin
               irq_flag_d = 1'b0;
               state_d    = TIMER_LOAD;
            end else begin
               // One-shot: flag stays up until software writes CTRL.
               ctrl_d[CTRL_EN_BIT] = 1'b0;
               state_d             = TIMER_IDLE;
            end
         end
         default: begin
            state_d = TIMER_IDLE;
         end
      endcase

      if (wr_commit) begin
         case (addr)
            CTRL_OFS: begin
               ctrl_d     = wdata[CTRL_W-1:0];
               irq_flag_d = 1'b0;
            end
            PRESET_OFS: begin
               preset_d = wdata[CNT_W-1:0];
            end
            default: begin
               // COUNT is read-only and the reserved slot has no storage.
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= TIMER_IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   // Read mux; narrower registers are zero-extended to the bus width.
   always_comb begin
      rdata = 32'h0;
      case (addr)
         CTRL_OFS:   rdata = 32'(ctrl_q);
         PRESET_OFS: rdata = 32'(preset_q);
         COUNT_OFS:  rdata = 32'(count_q);
         default:    rdata = 32'h0;
      endcase
   end

   assign irq = irq_flag_q & ctrl_q[CTRL_IM_BIT];

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
//   Directed bench for timer_unit: a register-access vector table followed by
//   hand-written timing sequences (one-shot, auto-reload, PRESET 0/1,
//   write-during-INT, disable/re-enable, asynchronous reset).
// -----------------------------------------------------------------------------
module tb_timer_unit;

   logic        clk;
   logic        reset_n;
   logic        sel;
   logic [1:0]  addr;
   logic [3:0]  wr_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_cmp;
   int n_err;

   timer_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sel     (sel),
      .addr    (addr),
      .wr_en   (wr_en),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr_sel;
      logic [1:0]  wr_addr;
      logic [3:0]  wr_be;
      logic [31:0] wr_data;
      logic [1:0]  rd_addr;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Drive a bus write on the falling edge; it commits on the next rising edge.
   task automatic bus_write(input logic s, input logic [1:0] a, input logic [3:0] be,
                            input logic [31:0] d);
      @(negedge clk);
      sel   = s;
      addr  = a;
      wr_en = be;
      wdata = d;
      @(posedge clk);
      #1;
      sel   = 1'b0;
      wr_en = 4'b0000;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_write(1'b1, a, 4'b1111, d);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(name, rdata, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      sel     = 1'b0;
      addr    = 2'd0;
      wr_en   = 4'b0000;
      wdata   = 32'h0;

      // ---------------- reset state ----------------
      tick(2);
      rd_chk("rst_ctrl",   2'd0, 32'h0);
      rd_chk("rst_preset", 2'd1, 32'h0);
      rd_chk("rst_count",  2'd2, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // ---------------- register access table (EN kept 0) ----------------
      vecs[0] = '{1'b1, 2'd1, 4'b1111, 32'h0000_0005, 2'd1, 32'h0000_0005, 1'b0};
      vecs[1] = '{1'b1, 2'd1, 4'b0011, 32'h0000_00AA, 2'd1, 32'h0000_0005, 1'b0};
      vecs[2] = '{1'b1, 2'd2, 4'b1111, 32'h0000_1234, 2'd2, 32'h0000_0000, 1'b0};
      vecs[3] = '{1'b1, 2'd0, 4'b1111, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006, 1'b0};
      vecs[4] = '{1'b1, 2'd3, 4'b1111, 32'h0000_DEAD, 2'd3, 32'h0000_0000, 1'b0};
      vecs[5] = '{1'b1, 2'd0, 4'b1111, 32'h0000_0000, 2'd0, 32'h0000_0000, 1'b0};
      vecs[6] = '{1'b0, 2'd1, 4'b1111, 32'h0000_0077, 2'd1, 32'h0000_0005, 1'b0};
      vecs[7] = '{1'b1, 2'd1, 4'b1111, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF, 1'b0};
      vecs[8] = '{1'b1, 2'd1, 4'b1110, 32'h0000_0003, 2'd1, 32'hFFFF_FFFF, 1'b0};
      vecs[9] = '{1'b1, 2'd1, 4'b1111, 32'h0000_0003, 2'd1, 32'h0000_0003, 1'b0};

      for (int i = 0; i < 10; i++) begin
         bus_write(vecs[i].wr_sel, vecs[i].wr_addr, vecs[i].wr_be, vecs[i].wr_data);
         rd_chk($sformatf("vec%0d_rdata", i), vecs[i].rd_addr, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      end

      // ---------------- async reset while counting ----------------
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      tick(3);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_irq", 32'(irq), 32'h0);
      rd_chk("arst_ctrl",   2'd0, 32'h0);
      rd_chk("arst_preset", 2'd1, 32'h0);
      rd_chk("arst_count",  2'd2, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(4);
      rd_chk("arst_idle_count", 2'd2, 32'h0);
      chk("arst_idle_irq", 32'(irq), 32'h0);

      // ---------------- one-shot, PRESET=3 ----------------
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk($sformatf("os_irq_e%0d", k), 32'(irq), (k == 5) ? 32'h1 : 32'h0);
      end
      rd_chk("os_count", 2'd2, 32'h0);
      tick(1);
      rd_chk("os_en_cleared", 2'd0, 32'h8);
      tick(3);
      chk("os_irq_held", 32'(irq), 32'h1);
      wr(2'd0, 32'h0);
      chk("os_irq_cleared", 32'(irq), 32'h0);

      // ---------------- MODE=01, PRESET=2 ----------------
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 12; k++) begin
         tick(1);
`ifdef TIMER_AUTORELOAD_EN
         chk($sformatf("ar_irq_e%0d", k), 32'(irq), ((k % 4) == 0) ? 32'h1 : 32'h0);
         if (k == 6) rd_chk("ar_reload_count", 2'd2, 32'h2);
`else
         chk($sformatf("ar_irq_e%0d", k), 32'(irq), (k >= 4) ? 32'h1 : 32'h0);
`endif
      end
`ifdef TIMER_AUTORELOAD_EN
      rd_chk("ar_ctrl", 2'd0, 32'hB);
`else
      rd_chk("ar_ctrl", 2'd0, 32'hA);
`endif
      wr(2'd0, 32'h0);
      tick(3);

      // ---------------- PRESET=0 ----------------
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk($sformatf("p0_irq_e%0d", k), 32'(irq), (k >= 3) ? 32'h1 : 32'h0);
         if (k >= 2) rd_chk($sformatf("p0_count_e%0d", k), 2'd2, 32'h0);
      end
      wr(2'd0, 32'h0);
      tick(2);

      // ---------------- PRESET=1, then CTRL write during INT ----------------
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         chk($sformatf("p1_irq_e%0d", k), 32'(irq), (k == 3) ? 32'h1 : 32'h0);
         if (k >= 2) rd_chk($sformatf("p1_count_e%0d", k), 2'd2, (k == 2) ? 32'h1 : 32'h0);
      end
      // FSM is in INT now; this write lands on the edge that would clear EN.
      wr(2'd0, 32'h9);
      rd_chk("wint_ctrl_en_kept", 2'd0, 32'h9);
      chk("wint_irq_cleared", 32'(irq), 32'h0);
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         chk($sformatf("wint_restart_irq_e%0d", k), 32'(irq), (k == 3) ? 32'h1 : 32'h0);
      end
      wr(2'd0, 32'h0);
      tick(2);

      // ---------------- disable at COUNT=6, re-enable, async reset ----------------
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      tick(5);
      rd_chk("dis_count7", 2'd2, 32'd7);
      wr(2'd0, 32'h8);
      rd_chk("dis_count6", 2'd2, 32'd6);
      tick(4);
      rd_chk("dis_count_held", 2'd2, 32'd6);
      chk("dis_no_irq", 32'(irq), 32'h0);
      wr(2'd0, 32'h9);
      tick(2);
      rd_chk("reen_reload", 2'd2, 32'd10);
      tick(2);
      rd_chk("reen_count8", 2'd2, 32'd8);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      rd_chk("midrst_count", 2'd2, 32'h0);
      rd_chk("midrst_ctrl",  2'd0, 32'h0);
      chk("midrst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
